// File: rtl/ysyx_24080006_axi_sram_slave_pkg.sv
// Shared AXI types for the SRAM responder: channel structs, burst encodings,
// FSM state enums and the per-channel beat context.
package ysyx_24080006_axi_sram_slave_pkg;

    localparam logic [31:0] RST_ADDR = 32'h8000_0000;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } axi_wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } axi_rd_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        axi_burst_e  burst;
        logic [7:0]  cnt;
    } axi_beat_ctx_t;

    typedef struct packed {
        logic        awvalid;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        wvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        bready;
    } axi_w_m2s_t;

    typedef struct packed {
        logic awready;
        logic wready;
        logic bvalid;
    } axi_w_s2m_t;

    typedef struct packed {
        logic        arvalid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        rlast;
    } axi_r_s2m_t;

endpackage

// File: rtl/ysyx_24080006_axi_burst_addr.sv
// Next-beat address calculator. FIXED holds the address; every other burst
// encoding (including WRAP and the reserved one) steps by the beat size.
module ysyx_24080006_axi_burst_addr
    import ysyx_24080006_axi_sram_slave_pkg::*;
(
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_size,
    input  axi_burst_e  i_burst,
    output logic [31:0] o_next_addr
);

    // FIXED bursts revisit the same address, all others advance by 1 << size
    always_comb begin
        o_next_addr = i_addr + (32'd1 << i_size);
        if (i_burst == FIXED) begin
            o_next_addr = i_addr;
        end
    end

endmodule

// File: rtl/ysyx_24080006_axi_sram_slave.sv
// AXI4 SRAM responder: independent write and read FSMs over a word-addressed
// array, with FIXED/INCR bursts, byte strobes and a configurable read latency.
module ysyx_24080006_axi_sram_slave
    import ysyx_24080006_axi_sram_slave_pkg::*;
#(
    parameter int          MEM_WORDS  = 4096,
    parameter logic [31:0] BASE_ADDR  = RST_ADDR,
    parameter int          RD_LATENCY = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  axi_w_m2s_t w_m2s,
    output axi_w_s2m_t w_s2m,
    input  axi_r_m2s_t r_m2s,
    output axi_r_s2m_t r_s2m
);

    localparam int          IDX_W    = $clog2(MEM_WORDS);
    localparam logic [15:0] LAT_LOAD = 16'(RD_LATENCY - 1);

    logic [31:0]      r_mem [MEM_WORDS];
    axi_wr_state_e    r_wrState;
    axi_beat_ctx_t    r_wrCtx;
    axi_rd_state_e    r_rdState;
    axi_beat_ctx_t    r_rdCtx;
    logic [15:0]      r_latCnt;

    logic [31:0]      w_wrNext;
    logic [31:0]      w_rdNext;
    logic [31:0]      w_wrOff;
    logic [31:0]      w_rdOff;
    logic [IDX_W-1:0] w_wrIdx;
    logic [IDX_W-1:0] w_rdIdx;
    logic             w_wHs;
    logic             w_rHs;
    logic             w_rdLast;
    logic             w_unused;

    // Out-of-range addresses alias because only the index bits are kept
    assign w_wrOff  = r_wrCtx.addr - BASE_ADDR;
    assign w_rdOff  = r_rdCtx.addr - BASE_ADDR;
    assign w_wrIdx  = w_wrOff[IDX_W+1:2];
    assign w_rdIdx  = w_rdOff[IDX_W+1:2];
    assign w_wHs    = (r_wrState == W_DATA) && w_m2s.wvalid;
    assign w_rHs    = (r_rdState == R_DATA) && r_m2s.rready;
    assign w_rdLast = (r_rdCtx.cnt == r_rdCtx.len);

    // Burst length comes from the beat counter alone, so wlast is not consulted
    assign w_unused = ^{w_m2s.wlast, w_wrOff[1:0], w_wrOff[31:IDX_W+2],
                        w_rdOff[1:0], w_rdOff[31:IDX_W+2]};

    ysyx_24080006_axi_burst_addr u_wrAddr (
        .i_addr      (r_wrCtx.addr),
        .i_size      (r_wrCtx.size),
        .i_burst     (r_wrCtx.burst),
        .o_next_addr (w_wrNext)
    );

    ysyx_24080006_axi_burst_addr u_rdAddr (
        .i_addr      (r_rdCtx.addr),
        .i_size      (r_rdCtx.size),
        .i_burst     (r_rdCtx.burst),
        .o_next_addr (w_rdNext)
    );

    // Write channel: accept AW, absorb len+1 W beats, then hold B until taken
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wrState <= W_IDLE;
            r_wrCtx   <= '0;
        end else begin
            case (r_wrState)
                W_IDLE: begin
                    if (w_m2s.awvalid) begin
                        r_wrCtx.addr  <= w_m2s.awaddr;
                        r_wrCtx.len   <= w_m2s.awlen;
                        r_wrCtx.size  <= w_m2s.awsize;
                        r_wrCtx.burst <= axi_burst_e'(w_m2s.awburst);
                        r_wrCtx.cnt   <= 8'd0;
                        r_wrState     <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_m2s.wvalid) begin
                        r_wrCtx.addr <= w_wrNext;
                        r_wrCtx.cnt  <= r_wrCtx.cnt + 8'd1;
                        if (r_wrCtx.cnt == r_wrCtx.len) begin
                            r_wrState <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (w_m2s.bready) begin
                        r_wrState <= W_IDLE;
                    end
                end
                default: r_wrState <= W_IDLE;
            endcase
        end
    end

    // Memory array is never reset; each set strobe bit updates one byte lane
    always_ff @(posedge clock) begin
        if (w_wHs) begin
            for (int b = 0; b < 4; b++) begin
                if (w_m2s.wstrb[b]) begin
                    r_mem[w_wrIdx][8*b +: 8] <= w_m2s.wdata[8*b +: 8];
                end
            end
        end
    end

    // Read channel: accept AR, wait out the latency, then stream len+1 beats
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdState <= R_IDLE;
            r_rdCtx   <= '0;
            r_latCnt  <= '0;
        end else begin
            case (r_rdState)
                R_IDLE: begin
                    if (r_m2s.arvalid) begin
                        r_rdCtx.addr  <= r_m2s.araddr;
                        r_rdCtx.len   <= r_m2s.arlen;
                        r_rdCtx.size  <= r_m2s.arsize;
                        r_rdCtx.burst <= axi_burst_e'(r_m2s.arburst);
                        r_rdCtx.cnt   <= 8'd0;
                        r_latCnt      <= LAT_LOAD;
                        r_rdState     <= (LAT_LOAD != 16'd0) ? R_WAIT : R_DATA;
                    end
                end
                R_WAIT: begin
                    r_latCnt <= r_latCnt - 16'd1;
                    if (r_latCnt == 16'd1) begin
                        r_rdState <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (w_rHs) begin
                        r_rdCtx.addr <= w_rdNext;
                        r_rdCtx.cnt  <= r_rdCtx.cnt + 8'd1;
                        if (w_rdLast) begin
                            r_rdState <= R_IDLE;
                        end
                    end
                end
                default: r_rdState <= R_IDLE;
            endcase
        end
    end

    // Write-side outputs; awready is gated so nothing is offered during reset
    always_comb begin
        w_s2m         = '0;
        w_s2m.awready = (r_wrState == W_IDLE) && !reset;
        w_s2m.wready  = (r_wrState == W_DATA);
        w_s2m.bvalid  = (r_wrState == W_RESP);
    end

    // Read-side outputs; rdata is a live array read, forced to 0 when idle
    always_comb begin
        r_s2m         = '0;
        r_s2m.arready = (r_rdState == R_IDLE) && !reset;
        r_s2m.rvalid  = (r_rdState == R_DATA);
        if (r_rdState == R_DATA) begin
            r_s2m.rdata = r_mem[w_rdIdx];
            r_s2m.rlast = w_rdLast;
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_axi_sram_slave.sv
// Scoreboarded bench for the AXI SRAM responder. Two instances (read latency
// 1 and 3) are exercised in turn against a flat-array memory model.
module tb_ysyx_24080006_axi_sram_slave;
    import ysyx_24080006_axi_sram_slave_pkg::*;

    localparam int          MEM_W  = 256;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          BUDGET = 2000;
    localparam int          LAT0   = 1;
    localparam int          LAT1   = 3;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    axi_w_m2s_t  wM2s [2];
    axi_w_s2m_t  wS2m [2];
    axi_r_m2s_t  rM2s [2];
    axi_r_s2m_t  rS2m [2];

    logic [31:0] model [2][MEM_W];
    exp_t        sbq [$];
    exp_t        monEntry;
    logic [31:0] wrData [$];
    logic [3:0]  wrStrb [$];
    logic [31:0] holdData [2];
    logic        holdLast [2];
    bit          holdPend [2];
    int          nChecks;
    int          nFails;

    always #5 clock = ~clock;

    ysyx_24080006_axi_sram_slave #(
        .MEM_WORDS (MEM_W), .BASE_ADDR (BASE), .RD_LATENCY (LAT0)
    ) uLat1 (
        .clock (clock), .reset (reset),
        .w_m2s (wM2s[0]), .w_s2m (wS2m[0]),
        .r_m2s (rM2s[0]), .r_s2m (rS2m[0])
    );

    ysyx_24080006_axi_sram_slave #(
        .MEM_WORDS (MEM_W), .BASE_ADDR (BASE), .RD_LATENCY (LAT1)
    ) uLat3 (
        .clock (clock), .reset (reset),
        .w_m2s (wM2s[1]), .w_s2m (wS2m[1]),
        .r_m2s (rM2s[1]), .r_s2m (rS2m[1])
    );

    function automatic int latOf(input int id);
        return (id == 0) ? LAT0 : LAT1;
    endfunction

    // Word slot in the model: byte offset from BASE, in words, modulo depth
    function automatic int wordIdx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off[31:2]) % MEM_W;
    endfunction

    // Address of beat k: FIXED stays put, everything else steps by 2**size
    function automatic logic [31:0] beatAddr(input logic [31:0] start, input int k,
                                             input logic [2:0] size, input logic [1:0] burst);
        if (burst == 2'b00) return start;
        return start + 32'(k) * (32'd1 << size);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAllZero(input string name);
        for (int i = 0; i < 2; i++) begin
            checkOutput({name, "_wctl"}, {29'd0, wS2m[i].awready, wS2m[i].wready, wS2m[i].bvalid}, 32'd0);
            checkOutput({name, "_rctl"}, {30'd0, rS2m[i].arready, rS2m[i].rvalid, rS2m[i].rlast}, 32'd0);
            checkOutput({name, "_rdata"}, rS2m[i].rdata, 32'd0);
        end
    endtask

    // Full write transaction: data/strobes come from wrData/wrStrb queues
    task automatic doWrite(input int id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int bStall, input int gapPct);
        int          t;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        @(posedge clock); #1;
        wM2s[id].awvalid = 1'b1;
        wM2s[id].awaddr  = addr;
        wM2s[id].awlen   = len;
        wM2s[id].awsize  = size;
        wM2s[id].awburst = burst;
        t = 0;
        @(negedge clock);
        while (!wS2m[id].awready && t < BUDGET) begin
            @(negedge clock);
            t++;
        end
        if (t >= BUDGET) begin
            checkOutput("aw_timeout", 32'(t), 32'd0);
            wM2s[id].awvalid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        wM2s[id].awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            while (int'($urandom_range(99)) < gapPct) begin
                @(posedge clock); #1;
            end
            d = wrData.pop_front();
            s = wrStrb.pop_front();
            wM2s[id].wvalid = 1'b1;
            wM2s[id].wdata  = d;
            wM2s[id].wstrb  = s;
            wM2s[id].wlast  = (k == int'(len));
            @(negedge clock);
            checkOutput("wready", 32'(wS2m[id].wready), 32'd1);
            checkOutput("bvalid_early", 32'(wS2m[id].bvalid), 32'd0);
            if (wS2m[id].wready !== 1'b1) begin
                wM2s[id].wvalid = 1'b0;
                return;
            end
            a = beatAddr(addr, k, size, burst);
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[id][wordIdx(a)][8*b +: 8] = d[8*b +: 8];
            end
            @(posedge clock); #1;
            wM2s[id].wvalid = 1'b0;
        end
        for (int c = 0; c < bStall; c++) begin
            @(negedge clock);
            checkOutput("bvalid_hold", 32'(wS2m[id].bvalid), 32'd1);
            checkOutput("awready_blocked", 32'(wS2m[id].awready), 32'd0);
            @(posedge clock); #1;
        end
        wM2s[id].bready = 1'b1;
        @(negedge clock);
        checkOutput("bvalid", 32'(wS2m[id].bvalid), 32'd1);
        @(posedge clock); #1;
        wM2s[id].bready = 1'b0;
        @(negedge clock);
        checkOutput("awready_after_b", 32'(wS2m[id].awready), 32'd1);
        checkOutput("bvalid_cleared", 32'(wS2m[id].bvalid), 32'd0);
    endtask

    // Full read transaction: expected beats go to the scoreboard at AR time
    task automatic doRead(input int id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int stallPct);
        int          t;
        int          got;
        logic [31:0] a;
        exp_t        e;
        @(posedge clock); #1;
        rM2s[id].arvalid = 1'b1;
        rM2s[id].araddr  = addr;
        rM2s[id].arlen   = len;
        rM2s[id].arsize  = size;
        rM2s[id].arburst = burst;
        rM2s[id].rready  = 1'b0;
        t = 0;
        @(negedge clock);
        while (!rS2m[id].arready && t < BUDGET) begin
            @(negedge clock);
            t++;
        end
        if (t >= BUDGET) begin
            checkOutput("ar_timeout", 32'(t), 32'd0);
            rM2s[id].arvalid = 1'b0;
            return;
        end
        for (int k = 0; k <= int'(len); k++) begin
            a      = beatAddr(addr, k, size, burst);
            e.id   = id;
            e.data = model[id][wordIdx(a)];
            e.last = (k == int'(len));
            sbq.push_back(e);
        end
        @(posedge clock); #1;
        rM2s[id].arvalid = 1'b0;
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!rS2m[id].rvalid && t < BUDGET);
        checkOutput("first_rvalid_latency", 32'(t), 32'(latOf(id)));
        if (t >= BUDGET) return;
        got = 0;
        t   = 0;
        while (got <= int'(len) && t < BUDGET) begin
            @(posedge clock); #1;
            rM2s[id].rready = (int'($urandom_range(99)) >= stallPct);
            @(negedge clock);
            t++;
            if (rS2m[id].rvalid && rM2s[id].rready) got++;
        end
        @(posedge clock); #1;
        rM2s[id].rready = 1'b0;
        checkOutput("r_beats", 32'(got), 32'(int'(len) + 1));
        @(negedge clock);
        checkOutput("arready_after_r", 32'(rS2m[id].arready), 32'd1);
        checkOutput("rvalid_after_r", 32'(rS2m[id].rvalid), 32'd0);
    endtask

    // Abort a len=3 write during its third beat; beats 0-1 must persist
    task automatic resetMidBurst(input int id);
        logic [31:0] addr;
        logic [31:0] d;
        addr = BASE + 32'h100;
        @(posedge clock); #1;
        wM2s[id].awvalid = 1'b1;
        wM2s[id].awaddr  = addr;
        wM2s[id].awlen   = 8'd3;
        wM2s[id].awsize  = 3'd2;
        wM2s[id].awburst = 2'b01;
        @(negedge clock);
        checkOutput("rst_awready", 32'(wS2m[id].awready), 32'd1);
        @(posedge clock); #1;
        wM2s[id].awvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            d = $urandom;
            wM2s[id].wvalid = 1'b1;
            wM2s[id].wdata  = d;
            wM2s[id].wstrb  = 4'hF;
            @(negedge clock);
            checkOutput("rst_wready", 32'(wS2m[id].wready), 32'd1);
            if (k < 2) begin
                model[id][wordIdx(addr + 32'(4 * k))] = d;
                @(posedge clock); #1;
            end
        end
        #1 reset = 1'b1;
        #1 checkAllZero("rst_mid");
        wM2s[id].wvalid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checkOutput("rst_no_bvalid", 32'(wS2m[id].bvalid), 32'd0);
            checkOutput("rst_awready_idle", 32'(wS2m[id].awready), 32'd1);
        end
        doRead(id, addr, 8'd3, 3'd2, 2'b01, 0);
    endtask

    // Directed scenarios followed by a random write/read-back sweep
    task automatic applyStimulus(input int id);
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        $display("[TB] Exercising instance with read latency %0d", latOf(id));
        for (int k = 0; k < MEM_W; k++) begin
            wrData.push_back(32'd0);
            wrStrb.push_back(4'hF);
        end
        doWrite(id, BASE, 8'd255, 3'd2, 2'b01, 0, 0);

        wrData.push_back(32'hDEADBEEF);
        wrStrb.push_back(4'b0101);
        doWrite(id, BASE + 32'h10, 8'd0, 3'd2, 2'b01, 0, 0);
        doRead(id, BASE + 32'h10, 8'd0, 3'd2, 2'b01, 0);

        for (int k = 1; k <= 4; k++) begin
            wrData.push_back(32'(k));
            wrStrb.push_back(4'hF);
        end
        doWrite(id, BASE + 32'h20, 8'd3, 3'd2, 2'b01, 0, 0);
        doRead(id, BASE + 32'h20, 8'd3, 3'd2, 2'b01, 0);

        wrData.push_back(32'h12345678);
        wrStrb.push_back(4'hF);
        doWrite(id, BASE + 32'h40, 8'd0, 3'd2, 2'b01, 0, 0);
        doRead(id, BASE + 32'h40, 8'd2, 3'd2, 2'b00, 50);

        wrData.push_back($urandom);
        wrData.push_back($urandom);
        wrStrb.push_back(4'hF);
        wrStrb.push_back(4'b1100);
        fork
            doWrite(id, BASE + 32'h80, 8'd1, 3'd2, 2'b01, 5, 30);
            doRead(id, BASE + 32'h20, 8'd3, 3'd2, 2'b01, 40);
        join

        resetMidBurst(id);
        wrData.push_back(32'hA5A5_0001 + 32'(id));
        wrStrb.push_back(4'hF);
        doWrite(id, BASE + 32'h104, 8'd0, 3'd2, 2'b01, 1, 0);
        doRead(id, BASE + 32'h100, 8'd3, 3'd2, 2'b01, 20);

        wrData.push_back($urandom);
        wrStrb.push_back(4'hF);
        doWrite(id, BASE + 32'(MEM_W * 4), 8'd0, 3'd2, 2'b01, 0, 0);
        doRead(id, BASE, 8'd0, 3'd2, 2'b01, 0);

        for (int n = 0; n < 16; n++) begin
            addr  = BASE + 32'($urandom_range(2 * MEM_W * 4 - 1));
            len   = 8'($urandom_range(7));
            size  = 3'($urandom_range(2));
            burst = 2'($urandom_range(3));
            for (int k = 0; k <= int'(len); k++) begin
                wrData.push_back($urandom);
                wrStrb.push_back(4'($urandom_range(15)));
            end
            doWrite(id, addr, len, size, burst, int'($urandom_range(3)), 25);
            doRead(id, addr, len, size, burst, 30);
        end
    endtask

    // Scoreboard monitor plus hold-stability check on stalled R beats
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                holdPend[i] = 1'b0;
            end else begin
                if (holdPend[i]) begin
                    checkOutput("rvalid_stable", 32'(rS2m[i].rvalid), 32'd1);
                    checkOutput("rdata_stable", rS2m[i].rdata, holdData[i]);
                    checkOutput("rlast_stable", 32'(rS2m[i].rlast), 32'(holdLast[i]));
                end
                if (rS2m[i].rvalid && rM2s[i].rready) begin
                    if (sbq.size() == 0) begin
                        checkOutput("unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        monEntry = sbq.pop_front();
                        checkOutput("beat_instance", 32'(i), 32'(monEntry.id));
                        checkOutput("rdata", rS2m[i].rdata, monEntry.data);
                        checkOutput("rlast", 32'(rS2m[i].rlast), 32'(monEntry.last));
                    end
                end
                holdPend[i] = rS2m[i].rvalid && !rM2s[i].rready;
                holdData[i] = rS2m[i].rdata;
                holdLast[i] = rS2m[i].rlast;
            end
        end
    end

    // Hard stop in case a handshake never arrives
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reset checks, then each instance in turn, then the summary
    initial begin
        nChecks = 0;
        nFails  = 0;
        for (int i = 0; i < 2; i++) begin
            wM2s[i]     = '0;
            rM2s[i]     = '0;
            holdPend[i] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 checkAllZero("reset");
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            checkOutput("awready_post_reset", 32'(wS2m[i].awready), 32'd1);
            checkOutput("arready_post_reset", 32'(rS2m[i].arready), 32'd1);
        end
        applyStimulus(0);
        applyStimulus(1);
        repeat (5) @(posedge clock);
        checkOutput("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
